// File: rtl/blk_71a137_pkg.sv
// Shared defaults for the toggle-flop bank.
package blk_71a137_pkg;

   localparam int         T_DEFAULT_WIDTH     = 1;
   localparam logic [63:0] T_DEFAULT_RESET_VAL = 64'h0;

endpackage

// File: rtl/t_ff_cell.sv
// Single-bit toggle flop: q <= q ^ t each edge, async active-low reset to RESET_VAL.
module t_ff_cell
   import blk_71a137_pkg::*;
#(
   parameter logic RESET_VAL = T_DEFAULT_RESET_VAL[0]
) (
   input  logic clk,
   input  logic n_rst,
   input  logic t,
   output logic q
);

   always_ff @(posedge clk or negedge n_rst) begin
      if (!n_rst) begin
         q <= RESET_VAL;
      end else begin
         q <= q ^ t;
      end
   end

endmodule

// File: rtl/blk_71a137.sv
// Bank of WIDTH independent toggle flops; Q_n is the combinational complement of Q.
module blk_71a137
   import blk_71a137_pkg::*;
#(
   parameter int               WIDTH     = T_DEFAULT_WIDTH,
   parameter logic [WIDTH-1:0] RESET_VAL = WIDTH'(T_DEFAULT_RESET_VAL)
) (
   input  logic             clk,
   input  logic             n_rst,
   input  logic [WIDTH-1:0] T,
   output logic [WIDTH-1:0] Q,
   output logic [WIDTH-1:0] Q_n
);

   // One cell per bit; each cell sees only its own enable and reset value.
   for (genvar i = 0; i < WIDTH; i++) begin : g_cell
      t_ff_cell #(
         .RESET_VAL (RESET_VAL[i])
      ) u_cell (
         .clk   (clk),
         .n_rst (n_rst),
         .t     (T[i]),
         .q     (Q[i])
      );
   end

   assign Q_n = ~Q;

endmodule

// File: tb/tb_blk_71a137.sv
// Bench for blk_71a137: toggle-count parity model plus directed scenario checks.
module tb_blk_71a137;

   localparam logic [3:0] RV4 = 4'b1010;

   logic       clk;
   logic       n_rst;
   logic [0:0] t1;
   logic [0:0] q1, q1_n;
   logic [3:0] t4, q4, q4_n;

   int checks   = 0;
   int failures = 0;

   // Model: number of enabled edges per bit since the last reset.
   int cnt1;
   int cnt4 [4];
   bit model_ok = 1'b0;

   blk_71a137 u_dut1 (
      .clk   (clk),
      .n_rst (n_rst),
      .T     (t1),
      .Q     (q1),
      .Q_n   (q1_n)
   );

   blk_71a137 #(
      .WIDTH     (4),
      .RESET_VAL (RV4)
   ) u_dut4 (
      .clk   (clk),
      .n_rst (n_rst),
      .T     (t4),
      .Q     (q4),
      .Q_n   (q4_n)
   );

   initial begin
      clk = 1'b1;
      forever #5 clk = ~clk;
   end

   task automatic chk(input string name, input logic [3:0] act, input logic [3:0] exp);
      checks++;
      if (act !== exp) begin
         failures++;
         $display("FAIL %s at %0t: got %b expected %b", name, $time, act, exp);
      end
   endtask

   function automatic logic exp_q1();
      return cnt1[0];
   endfunction

   function automatic logic [3:0] exp_q4();
      logic [3:0] v;
      for (int i = 0; i < 4; i++) v[i] = RV4[i] ^ cnt4[i][0];
      return v;
   endfunction

   always @(posedge clk or negedge n_rst) begin
      if (!n_rst) begin
         cnt1 = 0;
         for (int i = 0; i < 4; i++) cnt4[i] = 0;
         model_ok = 1'b1;
      end else begin
         cnt1 = cnt1 + int'(t1[0]);
         for (int i = 0; i < 4; i++) cnt4[i] = cnt4[i] + int'(t4[i]);
      end
   end

   always @(negedge clk) begin
      if (model_ok) begin
         chk("model_q1",   {3'b000, q1},   {3'b000, exp_q1()});
         chk("model_q1_n", {3'b000, q1_n}, {3'b000, ~exp_q1()});
         chk("model_q4",   q4,   exp_q4());
         chk("model_q4_n", q4_n, ~exp_q4());
      end
   end

   task automatic at(input int unsigned tm);
      if ($time < tm) #(tm - $time);
   endtask

   initial begin
      n_rst = 1'b1;
      t1    = 1'b0;
      t4    = 4'b0000;
      #1 n_rst = 1'b0;
      #1;
      chk("rst_q1",   {3'b000, q1},   4'b0000);
      chk("rst_q1_n", {3'b000, q1_n}, 4'b0001);
      chk("rst_q4",   q4,   RV4);
      chk("rst_q4_n", q4_n, 4'b0101);
      at(5);  n_rst = 1'b1;
      at(11); chk("hold_after_rst", {3'b000, q1}, 4'b0000);

      at(15); t1 = 1'b1;
      at(21); chk("toggle_20", {3'b000, q1}, 4'b0001);
      at(25); t1 = 1'b0;
      at(31); chk("hold_30",   {3'b000, q1}, 4'b0001);
      at(35); t1 = 1'b1;
      at(41); chk("toggle_40", {3'b000, q1}, 4'b0000);
      at(45); t1 = 1'b0;
      at(51); chk("hold_50",   {3'b000, q1}, 4'b0000);

      // Six consecutive enabled edges: 1,0,1,0,1,0.
      at(55); t1 = 1'b1;
      for (int k = 0; k < 6; k++) begin
         at(61 + 10 * k);
         chk("cont_toggle", {3'b000, q1}, (k % 2 == 0) ? 4'b0001 : 4'b0000);
      end
      at(115); t1 = 1'b0; t4 = 4'b0011;
      at(121);
      chk("indep_q4",   q4,   4'b1001);
      chk("indep_q4_n", q4_n, 4'b0110);
      at(125); t4 = 4'b0000; t1 = 1'b1;
      at(131); chk("pre_rst_q1", {3'b000, q1}, 4'b0001);
      at(133); n_rst = 1'b0;
      #1;
      chk("async_rst_q1",   {3'b000, q1},   4'b0000);
      chk("async_rst_q1_n", {3'b000, q1_n}, 4'b0001);
      chk("async_rst_q4",   q4, RV4);
      at(135); t1 = 1'b0;
      at(136); n_rst = 1'b1;
      at(141); chk("post_rst_hold", {3'b000, q1}, 4'b0000);

      // Pulse on T between edges must not reach Q.
      at(142); t1 = 1'b1;
      at(144); t1 = 1'b0;
      at(145); chk("glitch_q1", {3'b000, q1}, 4'b0000);

      for (int k = 0; k < 20; k++) begin
         at(155 + 10 * k);
         t1 = 1'($urandom_range(0, 1));
         t4 = 4'($urandom_range(0, 15));
      end
      at(355); t1 = 1'b0; t4 = 4'b0000;
      at(380);
      $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
      $finish;
   end

endmodule

// File: doc/blk_71a137.md
T -- requirements
Module: t

Interface
REQ-001 Parameter WIDTH, default 1: number of independent toggle bits; legal range 1..64.
REQ-002 Parameter RESET_VAL, default all zeros (WIDTH bits): value loaded into Q while reset is asserted.
REQ-003 Port clk, input, 1 bit: single clock; all state updates occur on its rising edge.
REQ-004 Port n_rst, input, 1 bit: reset, asynchronous and active-low.
REQ-005 Port T, input, WIDTH bits: per-bit toggle enable, sampled on the rising edge of clk.
REQ-006 Port Q, output, WIDTH bits: registered flip-flop state.
REQ-007 Port Q_n, output, WIDTH bits: bitwise complement of Q, derived combinationally from Q.

Function
REQ-008 On each rising edge of clk with n_rst=1, each bit i SHALL take the value Q[i] XOR T[i].
REQ-009 T[i]=0 at the edge SHALL leave Q[i] unchanged.
REQ-010 T[i]=1 at the edge SHALL invert Q[i].
REQ-011 Latency: a change on T SHALL affect Q only at the next rising edge; Q SHALL have no combinational path from T.
REQ-012 Bits SHALL be fully independent; the value of T[j] SHALL have no effect on Q[i] for i != j.
REQ-013 T held at 1 for N consecutive edges SHALL make Q[i] alternate every edge, returning to its starting value after every even N.
REQ-014 Q SHALL change only on a rising edge of clk or on assertion of n_rst; glitches on T between edges SHALL have no effect.
REQ-015 Q_n SHALL equal ~Q at all times, including during reset.

Reset
REQ-016 n_rst=0 SHALL immediately force Q to RESET_VAL, without waiting for a clock edge.
REQ-017 Q SHALL hold RESET_VAL for as long as n_rst=0, regardless of clk and T.
REQ-018 When n_rst is deasserted, the first rising edge at which n_rst=1 SHALL apply the normal toggle rule to RESET_VAL.
REQ-019 Reset asserted in the middle of a toggle sequence SHALL discard the current state; no toggle history SHALL be retained.
REQ-020 After power-up, the output state SHALL be undefined until the first assertion of n_rst.

Structure
REQ-021 A shared package SHALL hold the default WIDTH constant and the default reset-value constant.
REQ-022 One sub-module, t_ff_cell, SHALL implement a single-bit toggle flop with asynchronous active-low reset and a per-cell reset-value parameter.
REQ-023 The module t SHALL instantiate WIDTH copies of t_ff_cell through a generate loop, passing bit i of RESET_VAL to cell i.
REQ-024 The module SHALL contain no other state beyond these WIDTH flops.

Verification
Setup for all scenarios: clk period 10 ns, clk starts high.
REQ-025 Reset scenario: n_rst=0 from t=0, deasserted at 5 ns, T=0 -> Q=0 and Q_n=1 throughout.
REQ-026 Toggle/hold scenario: after reset, T=1 at 15 ns, 0 at 25, 1 at 35, 0 at 45 -> Q=1 after the 20 ns edge, Q=1 at 30, Q=0 at 40, Q=0 at 50.
REQ-027 Continuous-toggle scenario: T=1 held for 6 edges -> Q follows 1,0,1,0,1,0.
REQ-028 Mid-operation reset scenario: Q=1, then n_rst pulsed low for 3 ns between edges -> Q=0 at once, before any clock edge.
REQ-029 Independence scenario: WIDTH=4, RESET_VAL=4'b1010, T=4'b0011 held for one edge -> Q=4'b1001 and Q_n=4'b0110.
